// File: rtl/mfp_irq_ctrl.sv
// Vectored interrupt controller: NUM_SRC edge/level sources -> prioritised irq + 8-bit vector.
// Latency: irq rises IRQ_DELAY+1 clk_en edges after trigger goes true; vec/vec_spur latch on iack rise.
// Backpressure: none; src and register writes are sampled on every clk_en, nothing is ever stalled.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   clk_en              bus-rate enable; every flop holds when low
//   src[NUM_SRC]        raw interrupt inputs (synchronous to clk)
//   reg_wr/addr/din     register write port (0 IER,1 IPR,2 ISR,3 IMR,4 AER,5 LVL,6 VR)
//   reg_dout            combinational readback of the addressed register
//   iack                CPU acknowledge cycle for this controller
//   irq                 registered interrupt request
//   vec, vec_spur       vector captured at iack rise, spurious flag
module mfp_irq_ctrl #(
    parameter int NUM_SRC   = 16,
    parameter int IDX_W     = $clog2(NUM_SRC),
    parameter int IRQ_DELAY = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clk_en,
    input  logic [NUM_SRC-1:0] src,
    input  logic               reg_wr,
    input  logic [2:0]         reg_addr,
    input  logic [NUM_SRC-1:0] reg_din,
    output logic [NUM_SRC-1:0] reg_dout,
    input  logic               iack,
    output logic               irq,
    output logic [7:0]         vec,
    output logic               vec_spur
);

    localparam logic [2:0] A_IER = 3'd0;
    localparam logic [2:0] A_IPR = 3'd1;
    localparam logic [2:0] A_ISR = 3'd2;
    localparam logic [2:0] A_IMR = 3'd3;
    localparam logic [2:0] A_AER = 3'd4;
    localparam logic [2:0] A_LVL = 3'd5;
    localparam logic [2:0] A_VR  = 3'd6;

    // VR keeps the vector base bits above the index field plus the S (software EOI) bit.
    localparam logic [7:0] VR_MASK = 8'((8'hFF << IDX_W) | 8'h08);
    localparam logic [3:0] DLY     = 4'(IRQ_DELAY);
    localparam logic [7:0] SPUR_VEC = 8'h18;

    logic [NUM_SRC-1:0] ier_q, ier_d;
    logic [NUM_SRC-1:0] ipr_q, ipr_d;
    logic [NUM_SRC-1:0] isr_q, isr_d;
    logic [NUM_SRC-1:0] imr_q, imr_d;
    logic [NUM_SRC-1:0] aer_q, aer_d;
    logic [NUM_SRC-1:0] lvl_q, lvl_d;
    logic [7:0]         vr_q, vr_d;
    logic [NUM_SRC-1:0] prev_s_q, prev_s_d;
    logic               iack_d_q, iack_d_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               irq_q, irq_d;
    logic [7:0]         vec_q, vec_d;
    logic               vec_spur_q, vec_spur_d;

    logic [NUM_SRC-1:0] s;
    logic [NUM_SRC-1:0] p;
    logic [IDX_W-1:0]   hp;
    logic [IDX_W:0]     hs;
    logic [IDX_W:0]     hp_p1;
    logic [NUM_SRC-1:0] hp_bit;
    logic               trigger;
    logic               iack_rise;
    logic [7:0]         din8;

    // Priority view of the current state (registered values only, so no src/iack -> irq path).
    always_comb begin
        s  = src ^ ~aer_q;
        p  = ipr_q & imr_q;
        hp = '0;
        hs = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (p[i]) begin
                hp = IDX_W'(i);
            end
            if (isr_q[i]) begin
                hs = (IDX_W+1)'(i + 1);
            end
        end
        hp_p1     = {1'b0, hp} + {{IDX_W{1'b0}}, 1'b1};
        hp_bit    = {{(NUM_SRC-1){1'b0}}, 1'b1} << hp;
        // Only a source strictly above everything in service may interrupt.
        trigger   = (p != '0) && (hp_p1 > hs);
        iack_rise = iack & ~iack_d_q;
        din8      = 8'(reg_din);
    end

    always_comb begin
        logic wr_ier, wr_ipr, wr_isr, wr_imr, wr_aer, wr_lvl, wr_vr;
        logic ack_valid;
        logic [NUM_SRC-1:0] ipr_clr, ipr_set, lvl_en, isr_clr, isr_set;

        ier_d      = ier_q;
        ipr_d      = ipr_q;
        isr_d      = isr_q;
        imr_d      = imr_q;
        aer_d      = aer_q;
        lvl_d      = lvl_q;
        vr_d       = vr_q;
        prev_s_d   = prev_s_q;
        iack_d_d   = iack_d_q;
        cnt_d      = cnt_q;
        irq_d      = irq_q;
        vec_d      = vec_q;
        vec_spur_d = vec_spur_q;

        wr_ier    = reg_wr && (reg_addr == A_IER);
        wr_ipr    = reg_wr && (reg_addr == A_IPR);
        wr_isr    = reg_wr && (reg_addr == A_ISR);
        wr_imr    = reg_wr && (reg_addr == A_IMR);
        wr_aer    = reg_wr && (reg_addr == A_AER);
        wr_lvl    = reg_wr && (reg_addr == A_LVL);
        wr_vr     = reg_wr && (reg_addr == A_VR);
        ack_valid = iack_rise && (p != '0);

        ipr_clr = '0;
        ipr_set = '0;
        lvl_en  = '0;
        isr_clr = '0;
        isr_set = '0;

        if (clk_en) begin
            prev_s_d = s;
            iack_d_d = iack;

            if (wr_ier) ier_d = reg_din;
            if (wr_imr) imr_d = reg_din;
            if (wr_aer) aer_d = reg_din;
            if (wr_lvl) lvl_d = reg_din;
            if (wr_vr)  vr_d  = din8 & VR_MASK;

            // Pending: clears from software/ack, then hardware sets override them.
            if (wr_ipr)    ipr_clr = ipr_clr | ~reg_din;
            if (wr_ier)    ipr_clr = ipr_clr | ~reg_din;
            if (ack_valid) ipr_clr = ipr_clr | (hp_bit & ~lvl_q);
            ipr_set = ier_q & ~lvl_q & s & ~prev_s_q;
            // Enabled level sources simply mirror the input.
            lvl_en  = ier_q & lvl_q;
            ipr_d   = (((ipr_q & ~ipr_clr) | ipr_set) & ~lvl_en) | (s & lvl_en);

            // In-service: ack set beats a same-cycle write clear.
            if (wr_isr)                 isr_clr = ~reg_din;
            if (ack_valid && vr_q[3])   isr_set = hp_bit;
            isr_d = (isr_q & ~isr_clr) | isr_set;
            // Dropping into auto-EOI empties the in-service set outright.
            if (wr_vr && !din8[3]) isr_d = '0;

            if (iack_rise) begin
                if (p != '0) begin
                    vec_d      = {vr_q[7:IDX_W], hp};
                    vec_spur_d = 1'b0;
                end else begin
                    vec_d      = SPUR_VEC;
                    vec_spur_d = 1'b1;
                end
            end

            // irq fires on the edge where the saturated count is already at the delay.
            if (!trigger) begin
                cnt_d = '0;
                irq_d = 1'b0;
            end else if (cnt_q == DLY) begin
                irq_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ier_q      <= '0;
            ipr_q      <= '0;
            isr_q      <= '0;
            imr_q      <= '0;
            aer_q      <= '0;
            lvl_q      <= '0;
            vr_q       <= '0;
            prev_s_q   <= '0;
            iack_d_q   <= 1'b0;
            cnt_q      <= '0;
            irq_q      <= 1'b0;
            vec_q      <= '0;
            vec_spur_q <= 1'b0;
        end else begin
            ier_q      <= ier_d;
            ipr_q      <= ipr_d;
            isr_q      <= isr_d;
            imr_q      <= imr_d;
            aer_q      <= aer_d;
            lvl_q      <= lvl_d;
            vr_q       <= vr_d;
            prev_s_q   <= prev_s_d;
            iack_d_q   <= iack_d_d;
            cnt_q      <= cnt_d;
            irq_q      <= irq_d;
            vec_q      <= vec_d;
            vec_spur_q <= vec_spur_d;
        end
    end

    always_comb begin
        case (reg_addr)
            A_IER:   reg_dout = ier_q;
            A_IPR:   reg_dout = ipr_q;
            A_ISR:   reg_dout = isr_q;
            A_IMR:   reg_dout = imr_q;
            A_AER:   reg_dout = aer_q;
            A_LVL:   reg_dout = lvl_q;
            A_VR:    reg_dout = NUM_SRC'(vr_q);
            default: reg_dout = '0;
        endcase
    end

    assign irq      = irq_q;
    assign vec      = vec_q;
    assign vec_spur = vec_spur_q;

endmodule

// File: tb/tb_mfp_irq_ctrl.sv
// Directed bench for mfp_irq_ctrl: edge/level sources, nesting, spurious ack, set/clear race, async reset.
// Each bus step is two clocks with clk_en high on the first only, so gating is exercised throughout.
module tb_mfp_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk_en;
    logic [15:0] src;
    logic        reg_wr;
    logic [2:0]  reg_addr;
    logic [15:0] reg_din;
    logic [15:0] reg_dout;
    logic        iack;
    logic        irq;
    logic [7:0]  vec;
    logic        vec_spur;

    int n_chk  = 0;
    int n_pass = 0;

    mfp_irq_ctrl #(.NUM_SRC(16), .IDX_W(4), .IRQ_DELAY(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clk_en   (clk_en),
        .src      (src),
        .reg_wr   (reg_wr),
        .reg_addr (reg_addr),
        .reg_din  (reg_din),
        .reg_dout (reg_dout),
        .iack     (iack),
        .irq      (irq),
        .vec      (vec),
        .vec_spur (vec_spur)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One bus-rate step: a clk_en edge followed by a gated edge; returns 1 unit after the gated edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            clk_en = 1'b1;
            @(posedge clk);
            #1;
            clk_en = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        reg_wr   = 1'b1;
        reg_addr = a;
        reg_din  = d;
        tick();
        reg_wr   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [15:0] exp);
        reg_addr = a;
        #1;
        chk(tag, 32'(reg_dout), 32'(exp));
    endtask

    initial begin
        reset_n  = 1'b0;
        clk_en   = 1'b0;
        src      = '0;
        reg_wr   = 1'b0;
        reg_addr = '0;
        reg_din  = '0;
        iack     = 1'b0;
        #12;
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_vec", 32'(vec), 32'h00);
        chk("rst_spur", 32'(vec_spur), 32'd0);
        rd("rst_ier", 3'd0, 16'h0000);
        rd("rst_vr", 3'd6, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: edge source 0, auto-EOI, IRQ_DELAY=4
        wr(3'd4, 16'h0001);
        wr(3'd3, 16'h0001);
        wr(3'd0, 16'h0001);
        wr(3'd6, 16'h0040);
        src = 16'h0001;
        tick();
        src = 16'h0000;
        rd("s1_ipr_set", 3'd1, 16'h0001);
        tick(4);
        chk("s1_irq_early", 32'(irq), 32'd0);
        tick();
        chk("s1_irq_rise", 32'(irq), 32'd1);
        iack = 1'b1;
        tick();
        chk("s1_vec", 32'(vec), 32'h40);
        chk("s1_spur", 32'(vec_spur), 32'd0);
        rd("s1_ipr_clr", 3'd1, 16'h0000);
        tick();
        chk("s1_irq_drop", 32'(irq), 32'd0);
        chk("s1_no_reack", 32'(vec_spur), 32'd0);
        iack = 1'b0;
        tick();

        // 2: nesting with software EOI, VR=48
        wr(3'd4, 16'hFFFF);
        wr(3'd3, 16'hFFFF);
        wr(3'd0, 16'hFFFF);
        wr(3'd6, 16'h0048);
        rd("s2_vr", 3'd6, 16'h0048);
        src = 16'h0004;
        tick();
        src = 16'h0000;
        rd("s2_ipr2", 3'd1, 16'h0004);
        iack = 1'b1;
        tick();
        chk("s2_vec", 32'(vec), 32'h42);
        iack = 1'b0;
        tick();
        rd("s2_isr", 3'd2, 16'h0004);
        rd("s2_ipr_clr", 3'd1, 16'h0000);
        src = 16'h0002;
        tick();
        src = 16'h0000;
        tick(6);
        chk("s2_low_blocked", 32'(irq), 32'd0);
        rd("s2_ipr1", 3'd1, 16'h0002);
        src = 16'h0020;
        tick();
        src = 16'h0000;
        tick(4);
        chk("s2_hi_early", 32'(irq), 32'd0);
        tick();
        chk("s2_hi_irq", 32'(irq), 32'd1);
        wr(3'd2, 16'hFFFB);
        rd("s2_isr_clr", 3'd2, 16'h0000);
        wr(3'd1, 16'h0000);
        rd("s2_ipr_wclr", 3'd1, 16'h0000);

        // 3: level source 4
        wr(3'd6, 16'h0040);
        wr(3'd5, 16'h0010);
        wr(3'd3, 16'h0010);
        wr(3'd0, 16'h0010);
        src = 16'h0010;
        tick();
        rd("s3_ipr_lvl", 3'd1, 16'h0010);
        tick(5);
        chk("s3_irq", 32'(irq), 32'd1);
        iack = 1'b1;
        tick();
        chk("s3_vec", 32'(vec), 32'h44);
        iack = 1'b0;
        tick();
        rd("s3_ipr_hold", 3'd1, 16'h0010);
        chk("s3_irq_hold", 32'(irq), 32'd1);
        src = 16'h0000;
        tick();
        rd("s3_ipr_follow", 3'd1, 16'h0000);
        tick();
        chk("s3_irq_drop", 32'(irq), 32'd0);

        // 4: spurious acknowledge with everything masked
        wr(3'd5, 16'h0000);
        wr(3'd3, 16'h0000);
        wr(3'd0, 16'h0008);
        src = 16'h0008;
        tick();
        src = 16'h0000;
        tick();
        rd("s4_ipr3", 3'd1, 16'h0008);
        iack = 1'b1;
        tick();
        chk("s4_vec", 32'(vec), 32'h18);
        chk("s4_spur", 32'(vec_spur), 32'd1);
        iack = 1'b0;
        tick();
        rd("s4_ipr_kept", 3'd1, 16'h0008);
        tick(5);
        chk("s4_irq", 32'(irq), 32'd0);

        // 5: hardware set beats same-cycle IPR write clear
        wr(3'd0, 16'h0080);
        rd("s5_ier_clr", 3'd1, 16'h0000);
        reg_wr   = 1'b1;
        reg_addr = 3'd1;
        reg_din  = 16'h0000;
        src      = 16'h0080;
        tick();
        reg_wr   = 1'b0;
        src      = 16'h0000;
        rd("s5_set_wins", 3'd1, 16'h0080);
        wr(3'd0, 16'h0000);
        rd("s5_ier_wclr", 3'd1, 16'h0000);

        // 6: async reset while the delay counter is at 2
        wr(3'd6, 16'h0048);
        wr(3'd3, 16'h0003);
        wr(3'd0, 16'h0003);
        src = 16'h0001;
        tick();
        src = 16'h0000;
        iack = 1'b1;
        tick();
        chk("s6_vec", 32'(vec), 32'h40);
        iack = 1'b0;
        tick();
        rd("s6_isr", 3'd2, 16'h0001);
        src = 16'h0002;
        tick();
        src = 16'h0000;
        tick(2);
        chk("s6_pre_irq", 32'(irq), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("s6_irq", 32'(irq), 32'd0);
        chk("s6_vec_rst", 32'(vec), 32'h00);
        chk("s6_spur", 32'(vec_spur), 32'd0);
        rd("s6_ipr", 3'd1, 16'h0000);
        rd("s6_isr_rst", 3'd2, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        wr(3'd4, 16'h0003);
        wr(3'd3, 16'h0003);
        wr(3'd0, 16'h0003);
        tick(8);
        chk("s6_quiet", 32'(irq), 32'd0);
        rd("s6_ipr_quiet", 3'd1, 16'h0000);
        src = 16'h0002;
        tick();
        src = 16'h0000;
        tick(4);
        chk("s6_new_early", 32'(irq), 32'd0);
        tick();
        chk("s6_new_irq", 32'(irq), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
